// File: rtl/dec20_pkg.sv
// dec20_pkg: shared definitions for the 20-bit loadable down-counter.
//   DEC20_WIDTH : default counter/data width
//   state_t     : FSM encoding (IDLE/RUN/DONE); 2'd3 is illegal and
//                 recovers to IDLE in the counter FSM.
package dec20_pkg;

    localparam int DEC20_WIDTH = 20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/twenty_bit_dec.sv
// twenty_bit_dec: combinational WIDTH-bit ripple decrementer (a - 1).
// Bit 0 is a half-subtractor against constant 1; each higher bit is a
// half-subtractor fed by the borrow of the bit below.
//   a    : operand
//   out  : a - 1 modulo 2^WIDTH
//   bout : borrow out of the top bit (1 iff a == 0)
module twenty_bit_dec
    import dec20_pkg::*;
#(
    parameter int WIDTH = DEC20_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] out,
    output logic             bout
);

    logic br;

    // Borrow ripples upward; a bit passes the borrow on only while it is 0.
    always_comb begin
        br  = 1'b1;
        out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out[i] = a[i] ^ br;
            br     = br & ~a[i];
        end
        bout = br;
    end

endmodule

// File: rtl/dec20_down_counter.sv
// dec20_down_counter: registered loadable down-counter with a
// load/run/done handshake FSM.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val and start (highest priority, any state)
//   load_val   : start value; 0 goes straight to DONE
//   en         : decrement qualifier in RUN
//   ack        : releases DONE when HOLD_ON_DONE=1
//   count      : registered count
//   busy/done  : state == RUN / DONE (plus reload pulse in auto mode)
//   zero       : count == 0
//   borrow     : borrow-out of the decrement chain applied to count
// Optional build macro DEC20_AUTO_RELOAD_EN: the value captured on load is
// reloaded whenever RUN would reach 0; done pulses for that cycle while
// busy stays high. HOLD_ON_DONE is ignored in that build.
module dec20_down_counter
    import dec20_pkg::*;
#(
    parameter int WIDTH        = DEC20_WIDTH,
    parameter bit HOLD_ON_DONE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             borrow
);

`ifdef DEC20_AUTO_RELOAD_EN
    localparam bit AUTO_MODE = 1'b1;
`else
    localparam bit AUTO_MODE = 1'b0;
`endif
    localparam bit HOLD = HOLD_ON_DONE && !AUTO_MODE;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] dec_out;
    logic             dec_bout;

    twenty_bit_dec #(.WIDTH(WIDTH)) u_dec (
        .a    (count_q),
        .out  (dec_out),
        .bout (dec_bout)
    );

`ifdef DEC20_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic             reload_hit;
    logic             pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            if (load) reload_q <= load_val;
            pulse_q <= reload_hit;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef DEC20_AUTO_RELOAD_EN
        reload_hit = 1'b0;
`endif
        if (load) begin
            count_d = load_val;
            state_d = (load_val == '0) ? S_DONE : S_RUN;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_RUN: begin
                    if (en) begin
                        // dec_out == 0 means count is 1: this edge finishes.
                        if (dec_out == '0) begin
`ifdef DEC20_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d    = reload_q;
                                reload_hit = 1'b1;
                            end else begin
                                count_d = dec_out;
                                state_d = S_DONE;
                            end
`else
                            count_d = dec_out;
                            state_d = S_DONE;
`endif
                        end else begin
                            count_d = dec_out;
                        end
                    end
                end
                S_DONE: begin
                    if (!HOLD || ack) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign count  = count_q;
    assign busy   = (state_q == S_RUN);
    assign zero   = (count_q == '0);
    assign borrow = dec_bout;
`ifdef DEC20_AUTO_RELOAD_EN
    assign done   = (state_q == S_DONE) || pulse_q;
`else
    assign done   = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_dec20_down_counter.sv
// tb_dec20_down_counter: directed-vector bench for dec20_down_counter.
// dut runs with HOLD_ON_DONE=0, dut_h with HOLD_ON_DONE=1.
module tb_dec20_down_counter;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load, en, ack;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         busy, done, zero, borrow;

    logic         load_h, en_h, ack_h;
    logic [W-1:0] load_val_h;
    logic [W-1:0] count_h;
    logic         busy_h, done_h, zero_h, borrow_h;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dec20_down_counter #(.WIDTH(W), .HOLD_ON_DONE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .en(en), .ack(ack), .count(count), .busy(busy), .done(done),
        .zero(zero), .borrow(borrow)
    );

    dec20_down_counter #(.WIDTH(W), .HOLD_ON_DONE(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .load(load_h), .load_val(load_val_h),
        .en(en_h), .ack(ack_h), .count(count_h), .busy(busy_h), .done(done_h),
        .zero(zero_h), .borrow(borrow_h)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [W-1:0] c,
                             input logic b, input logic d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

`ifdef DEC20_AUTO_RELOAD_EN
    logic [W-1:0] ar_cnt  [6] = '{20'd1, 20'd2, 20'd1, 20'd2, 20'd1, 20'd2};
    logic         ar_done [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    logic         g_en  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] g_cnt [6] = '{20'd3, 20'd3, 20'd2, 20'd1, 20'd1, 20'd0};
`endif

    initial begin
        rst_n = 1'b0; load = 1'b0; en = 1'b0; ack = 1'b0; load_val = '0;
        load_h = 1'b0; en_h = 1'b0; ack_h = 1'b0; load_val_h = '0;
        #1;
        // Reset state, and the chain driven with 0 wraps to all ones.
        chk_state("reset", 20'h0, 1'b0, 1'b0);
        chk("reset.zero",   32'(zero),   32'h1);
        chk("reset.borrow", 32'(borrow), 32'h1);
        chk("wrap.chain",   32'(dut.dec_out), 32'h000F_FFFF);
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("idle", 20'h0, 1'b0, 1'b0);

`ifndef DEC20_AUTO_RELOAD_EN
        // Basic countdown from 3.
        load = 1'b1; load_val = 20'h3; en = 1'b1;
        tick();
        load = 1'b0;
        chk_state("basic.c0", 20'h3, 1'b1, 1'b0);
        chk("basic.borrow", 32'(borrow), 32'h0);
        tick(); chk_state("basic.c1", 20'h2, 1'b1, 1'b0);
        tick(); chk_state("basic.c2", 20'h1, 1'b1, 1'b0);
        tick(); chk_state("basic.c3", 20'h0, 1'b0, 1'b1);
        chk("basic.zero", 32'(zero), 32'h1);
        tick(); chk_state("basic.idle", 20'h0, 1'b0, 1'b0);
        tick(); chk_state("basic.en_ign", 20'h0, 1'b0, 1'b0);

        // Zero load goes straight to DONE.
        load = 1'b1; load_val = 20'h0;
        tick();
        load = 1'b0;
        chk_state("zload.done", 20'h0, 1'b0, 1'b1);
        tick(); chk_state("zload.idle", 20'h0, 1'b0, 1'b0);

        // en gating: 4 enabled edges needed.
        load = 1'b1; load_val = 20'h4; en = 1'b0;
        tick();
        load = 1'b0;
        chk_state("gate.load", 20'h4, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            en = g_en[i];
            tick();
            chk_state($sformatf("gate.%0d", i), g_cnt[i],
                      (g_cnt[i] != 0), (g_cnt[i] == 0));
        end
        en = 1'b0;
        tick();
`endif

        // Boundary: max start value.
        load = 1'b1; load_val = 20'hFFFFF; en = 1'b1;
        tick();
        load = 1'b0;
        chk_state("max.load", 20'hFFFFF, 1'b1, 1'b0);
        tick();
        chk_state("max.dec", 20'hFFFFE, 1'b1, 1'b0);

        // Priority: load beats the count-to-zero edge.
        load = 1'b1; load_val = 20'h2;
        tick();
        load = 1'b0;
        tick();
        chk_state("prio.one", 20'h1, 1'b1, 1'b0);
        load = 1'b1; load_val = 20'h10;
        tick();
        load = 1'b0;
        chk_state("prio.load", 20'h10, 1'b1, 1'b0);

        // Asynchronous reset mid-RUN.
        load = 1'b1; load_val = 20'h5;
        tick();
        load = 1'b0;
        chk_state("arst.run", 20'h5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("arst.now", 20'h0, 1'b0, 1'b0);
        chk("arst.zero", 32'(zero), 32'h1);
        tick();
        chk_state("arst.hold", 20'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        en = 1'b0;
        tick();

`ifdef DEC20_AUTO_RELOAD_EN
        // Auto reload: 2,1,2,1,... with done pulses while busy.
        load = 1'b1; load_val = 20'h2; en = 1'b1;
        tick();
        load = 1'b0;
        chk_state("auto.load", 20'h2, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_state($sformatf("auto.%0d", i), ar_cnt[i], 1'b1, ar_done[i]);
        end
`else
        // HOLD_ON_DONE=1: done stays until ack.
        load_h = 1'b1; load_val_h = 20'h1; en_h = 1'b1;
        tick();
        load_h = 1'b0;
        chk("hold.busy", 32'(busy_h), 32'h1);
        tick();
        chk("hold.done0", 32'(done_h), 32'h1);
        chk("hold.cnt",   32'(count_h), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold.done%0d", i + 1), 32'(done_h), 32'h1);
        end
        ack_h = 1'b1;
        tick();
        ack_h = 1'b0;
        chk("hold.ack_done", 32'(done_h), 32'h0);
        chk("hold.ack_busy", 32'(busy_h), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dec20_down_counter.md
Name: dec20_down_counter

Overview:
- Registered 20-bit loadable down-counter. It is the decrement-direction counterpart of the team's 20-bit ripple incrementer.
- Built on a combinational ripple half-subtractor decrement chain. Adds a small FSM for load, count and terminal-count handshaking.
- Sits beside the PC/address path. Used for loop counts, countdown timers and stack-pointer style pre-decrement.

Parameters:
- WIDTH, 20, counter and data width in bits; all arithmetic is modulo 2^WIDTH.
- HOLD_ON_DONE, 0, if 1 the FSM stays in DONE until `ack`; if 0 DONE lasts exactly one cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  load `load_val` and start counting
- load_val  input  WIDTH  start value
- en  input  1  decrement enable (count qualifier)
- ack  input  1  acknowledges DONE (used only when HOLD_ON_DONE=1)
- count  output  WIDTH  current registered count
- busy  output  1  high in RUN
- done  output  1  high in DONE
- zero  output  1  combinational, `count == 0`
- borrow  output  1  combinational borrow-out of the decrement chain applied to `count` (1 iff count==0)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0, busy=0, done=0.
  - zero=1 and borrow=1 follow from count=0.
  - Reset mid-RUN aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- IDLE:
  - load=1 and load_val!=0: count<=load_val, go to RUN next cycle.
  - load=1 and load_val==0: count<=0, go directly to DONE.
  - en is ignored in IDLE.
- RUN:
  - Each cycle with en=1 and load=0: count<=count-1 through the decrement chain.
  - If count==1 on that edge: count becomes 0 and state goes to DONE.
  - en=0: count and state hold.
- DONE:
  - HOLD_ON_DONE=0: next cycle returns to IDLE.
  - HOLD_ON_DONE=1: stays until ack=1, then returns to IDLE on the next edge.
  - count holds 0. en is ignored.
- load priority: load=1 in any state overrides en and ack. It reloads count and enters RUN (or DONE if load_val==0) on the same edge.
  - Load in DONE therefore suppresses the return to IDLE.
- Latency:
  - load_val=N (N>0) with en held high: done asserts exactly N cycles after the load edge.
  - busy is high for N cycles.
- Wrap-around: the counter never decrements below 0 in RUN, because DONE is entered at 0. The decrement chain itself wraps 0 -> 2^WIDTH-1 with borrow=1; this is only visible through the `borrow` output.
- Simultaneous events:
  - load wins over a count-to-zero on the same edge.
  - ack and load on the same edge behave as load.

Optional Feature:
- Macro: DEC20_AUTO_RELOAD_EN.
- Defined:
  - An internal reload register captures load_val on every load.
  - When RUN would reach 0 (count==1 and en=1), count instead reloads the stored value and the FSM stays in RUN.
  - done pulses for that one cycle while busy remains 1; done and busy are not exclusive in this mode.
  - A stored reload value of 0 behaves as non-auto mode.
  - HOLD_ON_DONE is ignored.
- Undefined: no reload register exists; behaviour is exactly as above.

Decomposition:
- Shared package/header `dec20_pkg`:
  - DEC20_WIDTH=20.
  - State encoding constants: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
- Sub-module `twenty_bit_dec`:
  - Combinational WIDTH-bit ripple decrementer.
  - Bit 0 is a half-subtractor with constant 1; bits 1..WIDTH-1 are half-subtractors chained on borrow.
  - Ports: a, out, bout. Mirrors the incrementer structure.
  - Instantiated once; the top holds only the FSM and registers.

Test Plan:
- Reset: assert rst_n=0 mid-RUN with count=0x00005 -> count=0, busy=0, done=0, zero=1 asynchronously, before the next clk edge.
- Basic countdown: load_val=0x00003, load 1 cycle, en=1 -> count 3,2,1,0; done=1 exactly 3 cycles after the load edge, then IDLE next cycle.
- Zero load and en gating:
  - load_val=0 -> done=1 the next cycle, busy never asserts.
  - load_val=0x00004 with en toggling 1,0,1,1,0,1 -> done after 4 enabled edges.
- Boundary and wrap:
  - load_val=0xFFFFF, en=1 -> after 1 cycle count=0xFFFFE.
  - Force the chain input to 0 (IDLE, count=0) -> borrow=1 and the chain output equals 0xFFFFF.
- Priority: in RUN with count=1, en=1 and load=1 with load_val=0x00010 on the same edge -> count=0x00010, no done, busy stays 1.
- HOLD_ON_DONE=1: done held for 5 cycles without ack; ack=1 -> IDLE next edge.
- With DEC20_AUTO_RELOAD_EN: load 2, en=1 -> count 2,1,2,1,...; done pulses every 2 cycles while busy=1.
